// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Holds the controller state encoding, the hex glyph table and the frame geometry.
package sseg_pkg;

  localparam int FRAME_BITS = 64;
  localparam int DIGITS     = 8;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Segment order {a,b,c,d,e,f,g}, lit = 1; index = hex value.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,  // F E d C
    7'h1F, 7'h77, 7'h7B, 7'h7F,  // b A 9 8
    7'h70, 7'h5F, 7'h5B, 7'h33,  // 7 6 5 4
    7'h79, 7'h6D, 7'h30, 7'h7E   // 3 2 1 0
  };

endpackage

// File: rtl/sseg_hex_enc.sv
// Combinational encoder: 8 hex nibbles plus decimal points into the 64-bit
// segment frame, one byte {a..g,dp} per digit, optionally inverted.
module sseg_hex_enc
  import sseg_pkg::*;
(
  input  logic [31:0]           value,
  input  logic [7:0]            dp,
  input  logic                  invert,
  output logic [FRAME_BITS-1:0] frame
);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign frame[8*gi +: 8] = {HEX_GLYPH[value[4*gi +: 4]], dp[gi]} ^ {8{invert}};
    end
  endgenerate

endmodule

// File: rtl/sseg_ctrl.sv
// Round-robin display controller in front of the serial seven-segment shifter.
// Define SSEG_CTRL_BLINK_EN to add the blink_mask input and the blink phase logic.
module sseg_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1_000_000,
  parameter bit SEG_INVERT     = 1'b1,
  parameter int BLINK_CYCLES   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_value,
  input  logic [7:0]  a_dp,
  input  logic [7:0]  a_en,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_value,
  input  logic [7:0]  b_dp,
  input  logic [7:0]  b_en,
`ifdef SSEG_CTRL_BLINK_EN
  input  logic [7:0]  blink_mask,
`endif
  output logic [63:0] sh_din,
  output logic [7:0]  sh_digit_en,
  output logic        sh_start,
  input  logic        sh_idle,
  output logic        busy,
  output logic        last_grant
);

  localparam int TIMER_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [FRAME_BITS-1:0] BLANK_FRAME =
    {DIGITS{HEX_GLYPH[0], 1'b0}} ^ {FRAME_BITS{SEG_INVERT}};

  state_t                  state_reg, state_next;
  logic [TIMER_W-1:0]      timer_reg;
  logic                    last_grant_reg;
  logic [31:0]             stored_value_reg;
  logic [7:0]              stored_dp_reg;
  logic [7:0]              stored_en_reg;
  logic [FRAME_BITS-1:0]   sh_din_reg;
  logic [7:0]              sh_digit_en_reg;
  logic [FRAME_BITS-1:0]   enc_frame;
  logic [7:0]              shown_en;
  logic                    refresh_due;

  sseg_hex_enc u_enc (
    .value  (stored_value_reg),
    .dp     (stored_dp_reg),
    .invert (SEG_INVERT),
    .frame  (enc_frame)
  );

  always_comb begin
    state_next = state_reg;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    sh_start   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      SYNC: begin
        busy = 1'b0;
        if (sh_idle) state_next = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        // last_grant = 1 means B was served last, so A wins a tie.
        if (a_valid && (!b_valid || last_grant_reg)) begin
          a_ready    = 1'b1;
          state_next = LOAD;
        end else if (b_valid) begin
          b_ready    = 1'b1;
          state_next = LOAD;
        end else if (refresh_due) begin
          state_next = LOAD;
        end
      end
      LOAD:      state_next = START;
      START: begin
        sh_start   = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: if (!sh_idle) state_next = WAIT_DONE;
      WAIT_DONE: if (sh_idle) state_next = IDLE;
      default:   state_next = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= SYNC;
      timer_reg        <= '0;
      last_grant_reg   <= 1'b1;
      stored_value_reg <= '0;
      stored_dp_reg    <= '0;
      stored_en_reg    <= '0;
      sh_din_reg       <= BLANK_FRAME;
      sh_digit_en_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (a_ready) begin
        stored_value_reg <= a_value;
        stored_dp_reg    <= a_dp;
        stored_en_reg    <= a_en;
        last_grant_reg   <= 1'b0;
      end else if (b_ready) begin
        stored_value_reg <= b_value;
        stored_dp_reg    <= b_dp;
        stored_en_reg    <= b_en;
        last_grant_reg   <= 1'b1;
      end
      if (state_reg == IDLE) begin
        if (timer_reg != TIMER_MAX) timer_reg <= timer_reg + TIMER_W'(1);
      end else if (state_reg == WAIT_DONE && sh_idle) begin
        timer_reg <= '0;
      end
      if (state_reg == LOAD) begin
        sh_din_reg      <= enc_frame;
        sh_digit_en_reg <= shown_en;
      end
    end
  end

`ifdef SSEG_CTRL_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;
  logic               blink_pending_reg;
  logic [7:0]         stored_mask_reg;

  // A phase toggle wins over a same-cycle clear so the new phase is always sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg     <= '0;
      blink_phase_reg   <= 1'b0;
      blink_pending_reg <= 1'b0;
      stored_mask_reg   <= '0;
    end else begin
      if (blink_cnt_reg == BLINK_MAX) begin
        blink_cnt_reg     <= '0;
        blink_phase_reg   <= ~blink_phase_reg;
        blink_pending_reg <= 1'b1;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
        if (state_reg == IDLE && state_next == LOAD) blink_pending_reg <= 1'b0;
      end
      if (a_ready || b_ready) stored_mask_reg <= blink_mask;
    end
  end

  assign refresh_due = (timer_reg == TIMER_MAX) || blink_pending_reg;
  assign shown_en    = blink_phase_reg ? (stored_en_reg & ~stored_mask_reg) : stored_en_reg;
`else
  assign refresh_due = (timer_reg == TIMER_MAX);
  assign shown_en    = stored_en_reg;
`endif

  assign sh_din      = sh_din_reg;
  assign sh_digit_en = sh_digit_en_reg;
  assign last_grant  = last_grant_reg;

endmodule

// File: tb/tb_sseg_ctrl.sv
// Self-checking bench for sseg_ctrl: table vectors, held-request arbitration,
// random requests against a glyph-table reference model, refresh and async reset.
module tb_sseg_ctrl;

  localparam int  REFRESH = 1000;
  localparam bit  INV     = 1'b0;
  localparam int  LIMIT   = 3000;
  localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef struct {
    logic        av, bv;
    logic [31:0] aval;
    logic [7:0]  adp, aen;
    logic [31:0] bval;
    logic [7:0]  bdp, ben;
    logic        exp_g;
    logic [63:0] exp_din;
    logic [7:0]  exp_en;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic a_valid, b_valid, a_ready, b_ready;
  logic [31:0] a_value, b_value;
  logic [7:0]  a_dp, a_en, b_dp, b_en;
  logic [63:0] sh_din;
  logic [7:0]  sh_digit_en;
  logic sh_start, sh_idle, busy, last_grant;
`ifdef SSEG_CTRL_BLINK_EN
  logic [7:0] blink_mask = 8'h00;
`endif

  int vectors = 0, miscompares = 0;
  int start_cnt = 0, ready_cnt = 0, width_err = 0;
  bit hold_low = 1'b1;
  int shift_cnt = 0;
  logic prev_start = 1'b0, prev_ar = 1'b0, prev_br = 1'b0;

  // Reference model state
  logic        m_lg;
  logic [63:0] m_din;
  logic [7:0]  m_en;

  sseg_ctrl #(.REFRESH_CYCLES(REFRESH), .SEG_INVERT(INV), .BLINK_CYCLES(600)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_value(a_value), .a_dp(a_dp), .a_en(a_en),
    .b_valid(b_valid), .b_ready(b_ready), .b_value(b_value), .b_dp(b_dp), .b_en(b_en),
`ifdef SSEG_CTRL_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .sh_din(sh_din), .sh_digit_en(sh_digit_en), .sh_start(sh_start), .sh_idle(sh_idle),
    .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  // Shifter model: goes non-idle after a start, shifts 64 bits x 4 clocks.
  always @(negedge clk) begin
    if (hold_low) begin
      sh_idle = 1'b0;
      shift_cnt = 0;
    end else if (sh_start) begin
      sh_idle = 1'b0;
      shift_cnt = 256;
    end else if (shift_cnt > 0) begin
      shift_cnt = shift_cnt - 1;
      if (shift_cnt == 0) sh_idle = 1'b1;
    end else begin
      sh_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (sh_start && prev_start) width_err = width_err + 1;
    if (a_ready && prev_ar) width_err = width_err + 1;
    if (b_ready && prev_br) width_err = width_err + 1;
    if (sh_start) start_cnt = start_cnt + 1;
    if (a_ready || b_ready) ready_cnt = ready_cnt + 1;
    prev_start = sh_start;
    prev_ar = a_ready;
    prev_br = b_ready;
  end

  function automatic logic [63:0] model_frame(input logic [31:0] v, input logic [7:0] d);
    logic [63:0] f = '0;
    for (int i = 0; i < 8; i++) begin
      int nib = int'((v >> (4 * i)) & 32'hF);
      f = f + ((64'(GLYPH[nib]) * 2 + 64'(d[i])) << (8 * i));
    end
    return INV ? ~f : f;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors = vectors + 1;
    if (got !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors = vectors + 1;
    miscompares = miscompares + 1;
    $display("FAIL %s: timed out after %0d cycles, expected event", name, LIMIT);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output int who, output bit ok);
    ok = 1'b0;
    who = -1;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      if (a_ready || b_ready) begin
        who = a_ready ? (b_ready ? 2 : 0) : 1;
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_start(output logic [63:0] din, output logic [7:0] en, output bit ok);
    ok = 1'b0;
    din = '0;
    en = '0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      if (sh_start) begin
        din = sh_din;
        en = sh_digit_en;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_busy_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    a_valid = v.av; a_value = v.aval; a_dp = v.adp; a_en = v.aen;
    b_valid = v.bv; b_value = v.bval; b_dp = v.bdp; b_en = v.ben;
  endtask

  task automatic xfer(input string name, input vec_t v);
    int who;
    bit ok;
    logic [63:0] din;
    logic [7:0] en;
    drive(v);
    wait_ready(who, ok);
    if (!ok) begin timeout({name, "_ready"}); a_valid = 0; b_valid = 0; return; end
    check({name, "_grant"}, who, v.exp_g);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check({name, "_last_grant"}, last_grant, v.exp_g);
    wait_start(din, en, ok);
    if (!ok) begin timeout({name, "_start"}); return; end
`ifdef SSEG_CTRL_BLINK_EN
    if (en == (v.exp_en & ~blink_mask)) en = v.exp_en;
`endif
    check({name, "_din"}, din, v.exp_din);
    check({name, "_en"}, en, v.exp_en);
    $display("xfer %-14s grant=%s din=%h en=%h", name, who == 0 ? "A" : "B", din, en);
    m_lg = v.exp_g;
    m_din = v.exp_din;
    m_en = v.exp_en;
    wait_busy_low(ok);
    if (!ok) timeout({name, "_done"});
  endtask

  vec_t tbl [4];
  vec_t rv;

  initial begin
    int s0, r0, who, n;
    bit ok;
    logic [63:0] din;
    logic [7:0] en;

    tbl[0] = '{1'b1, 1'b0, 32'h0123_4567, 8'h01, 8'hFF, 32'h0, 8'h00, 8'h00,
               1'b0, 64'hFC60_DAF2_66B6_BEE1, 8'hFF};
    tbl[1] = '{1'b0, 1'b1, 32'h0, 8'h00, 8'h00, 32'h89AB_CDEF, 8'h80, 8'h0F,
               1'b1, 64'hFFF6_EE3E_9C7A_9E8E, 8'h0F};
    tbl[2] = '{1'b1, 1'b1, 32'h0, 8'h00, 8'h00, 32'h0123_4567, 8'h01, 8'hFF,
               1'b0, 64'hFCFC_FCFC_FCFC_FCFC, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 32'h0123_4567, 8'h01, 8'hFF, 32'h89AB_CDEF, 8'h80, 8'h0F,
               1'b1, 64'hFFF6_EE3E_9C7A_9E8E, 8'h0F};

    rst_n = 1'b0;
    a_valid = 0; b_valid = 0; a_value = 0; b_value = 0;
    a_dp = 0; b_dp = 0; a_en = 0; b_en = 0;
    m_lg = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_sh_start", sh_start, 0);
    check("rst_last_grant", last_grant, 1);
    check("rst_sh_din", sh_din, model_frame(32'h0, 8'h00));
    check("rst_sh_digit_en", sh_digit_en, 8'h00);

    // Shifter still non-idle after reset: no start may be issued.
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (300) tick();
    check("sync_no_start", start_cnt - s0, 0);
    check("sync_busy", busy, 0);
    hold_low = 1'b0;
`ifndef SSEG_CTRL_BLINK_EN
    repeat (900) tick();
    check("no_early_refresh", start_cnt - s0, 0);
`endif

    for (int i = 0; i < 4; i++) xfer($sformatf("table%0d", i), tbl[i]);

    // Both clients held: grants must alternate A, B, A, B.
    rv = '{1'b1, 1'b1, 32'hDEAD_BEEF, 8'h0F, 8'hF0, 32'hCAFE_0042, 8'h00, 8'h3C,
           1'b0, 64'h0, 8'h00};
    drive(rv);
    for (int k = 0; k < 4; k++) begin
      wait_ready(who, ok);
      if (!ok) begin timeout("held_ready"); break; end
      check($sformatf("held%0d_grant", k), who, k % 2);
      tick();
      if (k == 3) begin a_valid = 0; b_valid = 0; end
      wait_start(din, en, ok);
      if (!ok) begin timeout("held_start"); break; end
      check($sformatf("held%0d_din", k), din,
            (k % 2 == 0) ? model_frame(rv.aval, rv.adp) : model_frame(rv.bval, rv.bdp));
      $display("xfer held%0d          grant=%s din=%h en=%h", k, who == 0 ? "A" : "B", din, en);
      m_lg = 1'(k % 2);
      m_din = din;
      m_en = en;
      wait_busy_low(ok);
      if (!ok) begin timeout("held_done"); break; end
    end
    a_valid = 0;
    b_valid = 0;

    for (int i = 0; i < 12; i++) begin
      int r = int'($urandom_range(1, 3));
      rv.av = r[0]; rv.bv = r[1];
      rv.aval = $urandom; rv.adp = 8'($urandom); rv.aen = 8'($urandom);
      rv.bval = $urandom; rv.bdp = 8'($urandom); rv.ben = 8'($urandom);
      rv.exp_g = (rv.av && rv.bv) ? ~m_lg : !rv.av;
      rv.exp_din = rv.exp_g ? model_frame(rv.bval, rv.bdp) : model_frame(rv.aval, rv.adp);
      rv.exp_en = rv.exp_g ? rv.ben : rv.aen;
      xfer($sformatf("rand%0d", i), rv);
    end

`ifndef SSEG_CTRL_BLINK_EN
    // Idle: identical frame re-sent after exactly REFRESH idle cycles.
    for (int k = 0; k < 2; k++) begin
      r0 = ready_cnt;
      n = 1;
      for (int i = 0; i < LIMIT && !busy; i++) begin
        tick();
        if (!busy) n++;
      end
      check($sformatf("refresh%0d_idle_cycles", k), n, REFRESH);
      wait_start(din, en, ok);
      if (!ok) begin timeout("refresh_start"); break; end
      check($sformatf("refresh%0d_din", k), din, m_din);
      check($sformatf("refresh%0d_en", k), en, m_en);
      $display("xfer refresh%0d       grant=- din=%h en=%h", k, din, en);
      wait_busy_low(ok);
      check($sformatf("refresh%0d_no_ready", k), ready_cnt - r0, 0);
    end
`endif

    // Asynchronous reset while the shifter is busy.
    rv = '{1'b1, 1'b0, 32'h7654_3210, 8'hAA, 8'hFF, 32'h0, 8'h00, 8'h00, 1'b0, 64'h0, 8'h00};
    drive(rv);
    wait_ready(who, ok);
    if (!ok) timeout("midrst_ready");
    tick();
    a_valid = 1'b0;
    wait_start(din, en, ok);
    if (!ok) timeout("midrst_start");
    repeat (20) tick();
    check("midrst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    hold_low = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_last_grant", last_grant, 1);
    check("midrst_sh_din", sh_din, model_frame(32'h0, 8'h00));
    check("midrst_sh_digit_en", sh_digit_en, 8'h00);
    check("midrst_sh_start", sh_start, 0);
    m_lg = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    rv = '{1'b1, 1'b0, 32'h0F1E_2D3C, 8'h55, 8'hC3, 32'h0, 8'h00, 8'h00,
           1'b0, model_frame(32'h0F1E_2D3C, 8'h55), 8'hC3};
    drive(rv);
    s0 = start_cnt;
    r0 = ready_cnt;
    repeat (50) tick();
    check("postrst_no_start", start_cnt - s0, 0);
    check("postrst_no_ready", ready_cnt - r0, 0);
    hold_low = 1'b0;
    xfer("postrst", rv);

`ifdef SSEG_CTRL_BLINK_EN
    begin
      logic [7:0] seen [4];
      blink_mask = 8'h80;
      rv = '{1'b1, 1'b0, 32'h1111_1111, 8'h00, 8'hFF, 32'h0, 8'h00, 8'h00,
             1'b0, model_frame(32'h1111_1111, 8'h00), 8'hFF};
      xfer("blink_load", rv);
      for (int k = 0; k < 4; k++) begin
        wait_start(din, en, ok);
        if (!ok) begin timeout("blink_start"); break; end
        seen[k] = en;
        $display("xfer blink%0d         grant=- din=%h en=%h", k, din, en);
        check($sformatf("blink%0d_value", k), (en == 8'hFF) || (en == 8'h7F), 1);
        if (k > 0) check($sformatf("blink%0d_alternates", k), en != seen[k-1], 1);
        wait_busy_low(ok);
      end
    end
`endif

    check("pulse_width", width_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
